// File: rtl/tx_console_pkg.sv
// Shared types and default parameter values for the console capture block.
package tx_console_pkg;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_e;

    localparam int DEF_DATA_W     = 7;
    localparam int DEF_DEPTH      = 16;
    localparam bit DEF_ON_CHANGE  = 1'b0;
    localparam int CNT_W          = 16;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO; DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign w_pop_ok  = i_pop && (r_count != {(AW + 1){1'b0}});
    assign w_push_ok = i_push && ((r_count != FULL_CNT) || w_pop_ok);

    // Storage array, no reset needed for data.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW + 1){1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_full     = (r_count == FULL_CNT);
    assign o_empty    = (r_count == {(AW + 1){1'b0}});

endmodule

// File: rtl/tx_console_capture.sv
// Captures characters framed by START/STOP markers on a cpu console bus into a FIFO.
module tx_console_capture
    import tx_console_pkg::*;
#(
    parameter int               DATA_W     = DEF_DATA_W,
    parameter int               DEPTH      = DEF_DEPTH,
    parameter logic [DATA_W-1:0] START_CODE = {DATA_W{1'b0}},
    parameter logic [DATA_W-1:0] STOP_CODE  = {DATA_W{1'b1}},
    parameter bit               ON_CHANGE  = DEF_ON_CHANGE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              in_frame,
    output logic              frame_done,
    output logic              overflow,
    output logic [CNT_W-1:0]  char_count,
    output logic [CNT_W-1:0]  drop_count
);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [DATA_W-1:0]   r_prev;
    logic                r_first;
    logic                r_frame_done;
    logic                r_overflow;
    logic [CNT_W-1:0]    r_char_count;
    logic [CNT_W-1:0]    r_drop_count;
    logic                w_is_start;
    logic                w_is_stop;
    logic                w_capture;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_accept;
    logic                w_drop;

    assign w_is_start = (tx_in == START_CODE);
    assign w_is_stop  = (tx_in == STOP_CODE);
    assign w_pop      = !w_empty && out_ready;

    // Capture filter: markers are never stored; ON_CHANGE suppresses repeats.
    always_comb begin
        w_capture = 1'b0;
        if ((r_state == ST_CAPTURE) && !w_is_start && !w_is_stop) begin
            if (!ON_CHANGE || r_first || (tx_in != r_prev)) begin
                w_capture = 1'b1;
            end else begin
                w_capture = 1'b0;
            end
        end else begin
            w_capture = 1'b0;
        end
    end

    assign w_accept = w_capture && (!w_full || w_pop);
    assign w_drop   = w_capture && w_full && !w_pop;

    // Framing next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_is_start) w_state_nxt = ST_CAPTURE;
                else            w_state_nxt = ST_IDLE;
            end
            ST_CAPTURE: begin
                if (w_is_stop)  w_state_nxt = ST_IDLE;
                else            w_state_nxt = ST_CAPTURE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, sample history, flags and saturating counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_prev       <= {DATA_W{1'b0}};
            r_first      <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_char_count <= {CNT_W{1'b0}};
            r_drop_count <= {CNT_W{1'b0}};
        end else begin
            r_state      <= w_state_nxt;
            r_prev       <= tx_in;
            r_first      <= w_is_start;
            r_frame_done <= (r_state == ST_CAPTURE) && w_is_stop;
            r_overflow   <= r_overflow || w_drop;
            // A start marker opens a fresh frame count, also when restarting.
            if (w_is_start) begin
                r_char_count <= {CNT_W{1'b0}};
            end else if (w_accept && (r_char_count != {CNT_W{1'b1}})) begin
                r_char_count <= r_char_count + 1'b1;
            end else begin
                r_char_count <= r_char_count;
            end
            if (w_drop && (r_drop_count != {CNT_W{1'b1}})) begin
                r_drop_count <= r_drop_count + 1'b1;
            end else begin
                r_drop_count <= r_drop_count;
            end
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .i_rst_n     (reset),
        .i_push      (w_accept),
        .i_push_data (tx_in),
        .i_pop       (w_pop),
        .o_pop_data  (out_data),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign out_valid  = !w_empty;
    assign in_frame   = (r_state == ST_CAPTURE);
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;
    assign char_count = r_char_count;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_tx_console_capture.sv
// Scoreboard bench for tx_console_capture: default, ON_CHANGE=1 and DEPTH=4 instances.
module tb_tx_console_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  tx_a, tx_c, tx_d;
    logic        rdy_a, rdy_c, rdy_d;
    logic [6:0]  od_a, od_c, od_d;
    logic        ov_a, ov_c, ov_d;
    logic        inf_a, inf_c, inf_d;
    logic        fd_a, fd_c, fd_d;
    logic        of_a, of_c, of_d;
    logic [15:0] cc_a, cc_c, cc_d;
    logic [15:0] dc_a, dc_c, dc_d;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_n = 0;
    int fd_cnt_a = 0, fd_cnt_c = 0, fd_cnt_d = 0;
    int pops_d = 0;
    int prev_pop_a = 0, last_pop_a = 0;
    logic [6:0] exp_a[$];
    logic [6:0] exp_c[$];
    logic [6:0] exp_d[$];
    logic [6:0] mon_e;

    always #5 clk = ~clk;

    tx_console_capture u_a (
        .clk(clk), .reset(rst), .tx_in(tx_a), .out_data(od_a), .out_valid(ov_a),
        .out_ready(rdy_a), .in_frame(inf_a), .frame_done(fd_a), .overflow(of_a),
        .char_count(cc_a), .drop_count(dc_a));

    tx_console_capture #(.ON_CHANGE(1'b1)) u_c (
        .clk(clk), .reset(rst), .tx_in(tx_c), .out_data(od_c), .out_valid(ov_c),
        .out_ready(rdy_c), .in_frame(inf_c), .frame_done(fd_c), .overflow(of_c),
        .char_count(cc_c), .drop_count(dc_c));

    tx_console_capture #(.DEPTH(4)) u_d (
        .clk(clk), .reset(rst), .tx_in(tx_d), .out_data(od_d), .out_valid(ov_d),
        .out_ready(rdy_d), .in_frame(inf_d), .frame_done(fd_d), .overflow(of_d),
        .char_count(cc_d), .drop_count(dc_d));

    // Output monitor: every handshake pops the scoreboard and compares.
    always @(negedge clk) begin
        cyc_n++;
        if (fd_a) fd_cnt_a++;
        if (fd_c) fd_cnt_c++;
        if (fd_d) fd_cnt_d++;
        if (rst && ov_a && rdy_a) begin
            n_tests++;
            prev_pop_a = last_pop_a;
            last_pop_a = cyc_n;
            if (exp_a.size() == 0) begin
                n_fail++; $display("FAIL pop_a: got %h, expected no output", od_a);
            end else begin
                mon_e = exp_a.pop_front();
                if (od_a !== mon_e) begin n_fail++; $display("FAIL pop_a: got %h, expected %h", od_a, mon_e); end
            end
        end
        if (rst && ov_c && rdy_c) begin
            n_tests++;
            if (exp_c.size() == 0) begin
                n_fail++; $display("FAIL pop_c: got %h, expected no output", od_c);
            end else begin
                mon_e = exp_c.pop_front();
                if (od_c !== mon_e) begin n_fail++; $display("FAIL pop_c: got %h, expected %h", od_c, mon_e); end
            end
        end
        if (rst && ov_d && rdy_d) begin
            n_tests++;
            pops_d++;
            if (exp_d.size() == 0) begin
                n_fail++; $display("FAIL pop_d: got %h, expected no output", od_d);
            end else begin
                mon_e = exp_d.pop_front();
                if (od_d !== mon_e) begin n_fail++; $display("FAIL pop_d: got %h, expected %h", od_d, mon_e); end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) cyc();
        n_tests++; if (ov_a !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", ov_a); end
        n_tests++; if (inf_a !== 1'b0) begin n_fail++; $display("FAIL rst_in_frame: got %b expected 0", inf_a); end
        n_tests++; if (fd_a !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: got %b expected 0", fd_a); end
        n_tests++; if (of_a !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b expected 0", of_a); end
        n_tests++; if (cc_a !== 16'd0) begin n_fail++; $display("FAIL rst_char_count: got %0d expected 0", cc_a); end
        n_tests++; if (dc_a !== 16'd0) begin n_fail++; $display("FAIL rst_drop_count: got %0d expected 0", dc_a); end
        n_tests++; if (ov_d !== 1'b0) begin n_fail++; $display("FAIL rst_valid_d: got %b expected 0", ov_d); end
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        int fd0;
        fd0 = fd_cnt_a;
        exp_a.push_back(7'h48);
        exp_a.push_back(7'h69);
        tx_a = 7'h00; cyc();
        tx_a = 7'h48; cyc();
        tx_a = 7'h69; cyc();
        tx_a = 7'h7F; cyc();
        repeat (3) cyc();
        n_tests++; if (exp_a.size() != 0) begin n_fail++; $display("FAIL basic_drain: got %0d left expected 0", exp_a.size()); end
        n_tests++; if (last_pop_a - prev_pop_a != 1) begin n_fail++; $display("FAIL basic_consecutive: got gap %0d expected 1", last_pop_a - prev_pop_a); end
        n_tests++; if (cc_a !== 16'd2) begin n_fail++; $display("FAIL basic_char_count: got %0d expected 2", cc_a); end
        n_tests++; if (fd_cnt_a - fd0 != 1) begin n_fail++; $display("FAIL basic_frame_done: got %0d pulses expected 1", fd_cnt_a - fd0); end
        n_tests++; if (inf_a !== 1'b0) begin n_fail++; $display("FAIL basic_in_frame: got %b expected 0", inf_a); end
    endtask

    task automatic test_on_change();
        logic [6:0] seq [6];
        int fda0, fdc0;
        seq = '{7'h00, 7'h41, 7'h41, 7'h41, 7'h42, 7'h7F};
        fda0 = fd_cnt_a; fdc0 = fd_cnt_c;
        exp_a.push_back(7'h41); exp_a.push_back(7'h41); exp_a.push_back(7'h41); exp_a.push_back(7'h42);
        exp_c.push_back(7'h41); exp_c.push_back(7'h42);
        for (int i = 0; i < 6; i++) begin
            tx_a = seq[i]; tx_c = seq[i]; cyc();
        end
        repeat (3) cyc();
        n_tests++; if (exp_a.size() != 0) begin n_fail++; $display("FAIL chg_drain_a: got %0d left expected 0", exp_a.size()); end
        n_tests++; if (exp_c.size() != 0) begin n_fail++; $display("FAIL chg_drain_c: got %0d left expected 0", exp_c.size()); end
        n_tests++; if (cc_a !== 16'd4) begin n_fail++; $display("FAIL chg_count_a: got %0d expected 4", cc_a); end
        n_tests++; if (cc_c !== 16'd2) begin n_fail++; $display("FAIL chg_count_c: got %0d expected 2", cc_c); end
        n_tests++; if (fd_cnt_c - fdc0 != 1 || fd_cnt_a - fda0 != 1) begin
            n_fail++; $display("FAIL chg_frame_done: got %0d/%0d expected 1/1", fd_cnt_a - fda0, fd_cnt_c - fdc0);
        end
    endtask

    task automatic test_overflow();
        logic [6:0] ch;
        int p0;
        rdy_d = 1'b0;
        tx_d = 7'h00; cyc();
        for (int i = 0; i < 6; i++) begin
            ch = 7'h61 + 7'(i);
            if (i < 4) exp_d.push_back(ch);
            tx_d = ch; cyc();
        end
        n_tests++; if (dc_d !== 16'd2) begin n_fail++; $display("FAIL ovf_drop_count: got %0d expected 2", dc_d); end
        n_tests++; if (of_d !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", of_d); end
        n_tests++; if (cc_d !== 16'd4) begin n_fail++; $display("FAIL ovf_char_count: got %0d expected 4", cc_d); end
        exp_d.push_back(7'h67);
        rdy_d = 1'b1; tx_d = 7'h67; cyc();
        rdy_d = 1'b0; tx_d = 7'h7F; cyc();
        n_tests++; if (dc_d !== 16'd2) begin n_fail++; $display("FAIL full_pop_drop: got %0d expected 2", dc_d); end
        n_tests++; if (cc_d !== 16'd5) begin n_fail++; $display("FAIL full_pop_count: got %0d expected 5", cc_d); end
        p0 = pops_d;
        rdy_d = 1'b1;
        repeat (8) cyc();
        n_tests++; if (pops_d - p0 != 4) begin n_fail++; $display("FAIL full_occupancy: got %0d pops expected 4", pops_d - p0); end
        n_tests++; if (exp_d.size() != 0) begin n_fail++; $display("FAIL ovf_drain: got %0d left expected 0", exp_d.size()); end
        n_tests++; if (ov_d !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b expected 0", ov_d); end
    endtask

    task automatic test_reset_mid();
        int fd0;
        fd0 = fd_cnt_a;
        rdy_a = 1'b0;
        tx_a = 7'h00; cyc();
        tx_a = 7'h70; cyc();
        tx_a = 7'h71; cyc();
        tx_a = 7'h72; cyc();
        tx_a = 7'h7F;
        n_tests++; if (cc_a !== 16'd3 || inf_a !== 1'b1 || ov_a !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre: got count %0d frame %b valid %b expected 3 1 1", cc_a, inf_a, ov_a);
        end
        rst = 1'b0; cyc();
        n_tests++; if (ov_a !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", ov_a); end
        n_tests++; if (inf_a !== 1'b0) begin n_fail++; $display("FAIL mid_in_frame: got %b expected 0", inf_a); end
        n_tests++; if (cc_a !== 16'd0 || dc_a !== 16'd0) begin
            n_fail++; $display("FAIL mid_counts: got %0d/%0d expected 0/0", cc_a, dc_a);
        end
        rst = 1'b1; rdy_a = 1'b1;
        repeat (3) cyc();
        n_tests++; if (fd_cnt_a != fd0) begin n_fail++; $display("FAIL mid_frame_done: got %0d pulses expected 0", fd_cnt_a - fd0); end
        n_tests++; if (ov_a !== 1'b0) begin n_fail++; $display("FAIL mid_post_valid: got %b expected 0", ov_a); end
    endtask

    task automatic test_restart();
        logic [6:0] seq [6];
        int fd0;
        seq = '{7'h7F, 7'h00, 7'h78, 7'h00, 7'h79, 7'h7F};
        fd0 = fd_cnt_a;
        exp_a.push_back(7'h78); exp_a.push_back(7'h79);
        for (int i = 0; i < 6; i++) begin
            tx_a = seq[i]; cyc();
        end
        repeat (3) cyc();
        n_tests++; if (exp_a.size() != 0) begin n_fail++; $display("FAIL restart_drain: got %0d left expected 0", exp_a.size()); end
        n_tests++; if (cc_a !== 16'd1) begin n_fail++; $display("FAIL restart_count: got %0d expected 1", cc_a); end
        n_tests++; if (fd_cnt_a - fd0 != 1) begin n_fail++; $display("FAIL restart_frame_done: got %0d pulses expected 1", fd_cnt_a - fd0); end
    endtask

    task automatic test_back_to_back();
        int budget;
        tx_a = 7'h00; cyc();
        for (int i = 1; i <= 20; i++) begin
            exp_a.push_back(7'(i));
            rdy_a = (i % 3 != 0);
            tx_a = 7'(i); cyc();
        end
        rdy_a = 1'b1; tx_a = 7'h7F;
        budget = 0;
        while (exp_a.size() != 0 && budget < 40) begin cyc(); budget++; end
        cyc();
        n_tests++; if (exp_a.size() != 0) begin n_fail++; $display("FAIL b2b_drain: got %0d left expected 0", exp_a.size()); end
        n_tests++; if (cc_a !== 16'd20) begin n_fail++; $display("FAIL b2b_count: got %0d expected 20", cc_a); end
        n_tests++; if (of_a !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow: got %b expected 0", of_a); end
    endtask

    initial begin
        rst = 1'b0;
        tx_a = 7'h7F; tx_c = 7'h7F; tx_d = 7'h7F;
        rdy_a = 1'b1; rdy_c = 1'b1; rdy_d = 1'b1;
        test_reset();
        test_basic();
        test_on_change();
        test_overflow();
        test_reset_mid();
        test_restart();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
